modd_vec_pipe: RTL and testbench
================================

// Module: modd_vec_pipe
// PURPOSE
//  Pipelined, DIMS-axis minimum-image displacement unit for the pair-force datapath.
//  Per axis: d = b-a, picks the candidate in {d-M, d, d+M} with least |.|, per axis box length M.
//  Streams one particle pair per cycle under valid/ready. Carries an opaque tag (pair ID) alongside.
//  Sits between the cell-neighbour fetch and the force pipeline.
// PARAMETERS
//  W      32  coordinate/box width, signed two's complement
//  DIMS   3   number of axes processed in parallel
//  TAG_W  16  width of the pass-through tag
// PORTS
//  clk            in   1              clock
//  rst            in   1              synchronous, active-high reset
//  in_valid       in   1              input pair valid
//  in_ready       out  1              unit accepts input this cycle
//  in_a           in   DIMS*W         position A, axis k at [k*W +: W]
//  in_b           in   DIMS*W         position B, same packing
//  in_box         in   DIMS*W         box length per axis, sampled with the pair
//  in_tag         in   TAG_W          pair tag
//  out_valid      out  1              result valid
//  out_ready      in   1              downstream accepts result
//  out_disp       out  DIMS*(W+1)     signed displacement per axis
//  out_abs        out  DIMS*W         |disp| per axis, low W bits
//  out_tag        out  TAG_W          tag of the result
//  cutoff_sq      in   2*W+2          (MODD_R2_EN only) squared cutoff, unsigned
//  out_r2         out  2*W+2          (MODD_R2_EN only) sum of squared abs
//  out_in_cutoff  out  1              (MODD_R2_EN only) out_r2 <= cutoff_sq
// BEHAVIOUR
//  - Reset: all stage valids 0, out_valid=0, out_disp/out_abs/out_tag/out_r2/out_in_cutoff=0.
//  - in_ready = !rst && (out_ready || !out_valid); the same signal advances every stage (stall-all).
//  - Transfer on in_valid&&in_ready; result on out_valid&&out_ready. Order preserved, no drops or duplicates.
//  - Latency LAT=2 cycles accept->out_valid (LAT=3 with MODD_R2_EN). Throughput 1/cycle when out_ready held high.
//  - Internal bubbles are not compressed. Output regs hold stable while out_valid && !out_ready.
//  - Stage 1 (register): sign-extend a,b,M to W+2; d=b-a; c0=d-M, c1=d, c2=d+M.
//  - Stage 2 (register): abs of each candidate (W+2 bit). Pick min abs.
//  - Tie priority c0 > c1 > c2: sel0 = |c0|<=|c1| && |c0|<=|c2|; sel1 = |c1|<|c0| && |c1|<=|c2|; else c2.
//  - out_disp = chosen candidate truncated to W+1; out_abs = |chosen| low W bits (silent wrap, no saturation).
//  - Box M used as given; M<=0 is legal, no error flag.
//  - rst asserted mid-stream: all in-flight pairs discarded. in_ready=0 while rst=1.
//  - First accept possible the cycle after rst deasserts.
//  - Simultaneous out accept and in accept with pipeline full: both occur, occupancy unchanged.
// CONFIGURATION
//  - MODD_R2_EN defined: adds stage 3.
//  - Stage 3: out_r2 = sum_k abs_k^2 (each abs W bits, square 2W, sum 2W+2 bits, exact).
//  - Stage 3 also gives out_in_cutoff = (out_r2 <= cutoff_sq). cutoff_sq is sampled when the pair enters stage 3.
//  - LAT=3; cutoff_sq, out_r2 and out_in_cutoff ports exist.
//  - MODD_R2_EN undefined: stage 3 and those three ports are absent; LAT=2.
// STRUCTURE
//  - Package modd_pkg holds:
//    - default W/DIMS/TAG_W localparams
//    - the LAT constant per MODD_R2_EN
//    - a function packing/unpacking axis k of a DIMS-wide bus
//  - Sub-module modd_axis holds the per-axis stage-1/stage-2 registers and selection, with enable input.
//    It is instantiated DIMS times via generate.
//  - The top holds valid/tag pipeline, stall logic and the optional r2 stage.
// TESTING
//  - M=100, a=10, b=90 -> disp=-20, abs=20 after 2 cycles, tag echoed.
//  - Tie rule: M=100, a=0, b=50 -> disp=-50, abs=50 (c0 wins over c1).
//  - Extreme: a=-2^31, b=2^31-1, M=0 (W=32) -> disp=0x0_FFFF_FFFF, abs=0xFFFF_FFFF.
//  - Backpressure: stream 3 tagged pairs back-to-back while out_ready=0 for 5 cycles.
//    Expect in_ready=0 once full and outputs held stable. On release, tags 1,2,3 come out in order.
//  - Reset mid-stream: rst pulse with 2 pairs in flight -> no out_valid for them; next pair emerges at LAT.
//  - MODD_R2_EN, 3 axes: disp (3,4,0). cutoff_sq=25 -> out_r2=25, in_cutoff=1. cutoff_sq=24 -> in_cutoff=0.

Source files
------------

// File: rtl/modd_pkg.sv
// Shared constants and helpers for the minimum-image displacement pipe.
// Optional feature macro: MODD_R2_EN (adds the squared-distance / cutoff stage).
package modd_pkg;

    localparam int W_DEF     = 32;
    localparam int DIMS_DEF  = 3;
    localparam int TAG_W_DEF = 16;

`ifdef MODD_R2_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    // Which of the three periodic images was nearest
    typedef enum logic [1:0] {
        SEL_C0 = 2'd0,
        SEL_C1 = 2'd1,
        SEL_C2 = 2'd2
    } cand_sel_e;

    // Axis k of a default-width DIMS-wide coordinate bus
    function automatic logic [W_DEF-1:0] axis_get(
        input logic [DIMS_DEF*W_DEF-1:0] bus,
        input int                        k
    );
        return bus[k*W_DEF +: W_DEF];
    endfunction

    // Replace axis k of a default-width DIMS-wide coordinate bus
    function automatic logic [DIMS_DEF*W_DEF-1:0] axis_set(
        input logic [DIMS_DEF*W_DEF-1:0] bus,
        input int                        k,
        input logic [W_DEF-1:0]          v
    );
        logic [DIMS_DEF*W_DEF-1:0] r;
        r = bus;
        r[k*W_DEF +: W_DEF] = v;
        return r;
    endfunction

endpackage

// File: rtl/modd_axis.sv
// One axis of the minimum-image unit: stage 1 forms d-M, d, d+M at W+2 bits,
// stage 2 picks the smallest magnitude (ties favour c0, then c1).
// Optional feature macro: MODD_R2_EN (not used in this file).
module modd_axis
    import modd_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] m,
    output logic [W:0]   disp,
    output logic [W-1:0] abs_o
);

    localparam int XW = W + 2;

    logic [XW-1:0] a_x, b_x, m_x, d_x;
    logic [XW-1:0] c0_d, c1_d, c2_d;
    logic [XW-1:0] c0_q, c1_q, c2_q;
    logic [XW-1:0] abs0, abs1, abs2;
    cand_sel_e     sel;
    logic [W:0]    disp_d, disp_q;
    logic [W-1:0]  abs_d, abs_q;

    // Two's complement magnitude; candidates never reach -2^(XW-1) so no overflow
    function automatic logic [XW-1:0] mag(input logic [XW-1:0] x);
        return x[XW-1] ? ((~x) + XW'(1)) : x;
    endfunction

    // Stage 1 next-state: widen inputs and form the three image candidates
    always_comb begin
        a_x  = {{2{a[W-1]}}, a};
        b_x  = {{2{b[W-1]}}, b};
        m_x  = {{2{m[W-1]}}, m};
        d_x  = b_x - a_x;
        c0_d = d_x - m_x;
        c1_d = d_x;
        c2_d = d_x + m_x;
    end

    // Stage 2 next-state: nearest image, result truncated with silent wrap
    always_comb begin
        abs0 = mag(c0_q);
        abs1 = mag(c1_q);
        abs2 = mag(c2_q);
        if (abs0 <= abs1 && abs0 <= abs2)
            sel = SEL_C0;
        else if (abs1 < abs0 && abs1 <= abs2)
            sel = SEL_C1;
        else
            sel = SEL_C2;
        case (sel)
            SEL_C0: begin
                disp_d = c0_q[W:0];
                abs_d  = abs0[W-1:0];
            end
            SEL_C1: begin
                disp_d = c1_q[W:0];
                abs_d  = abs1[W-1:0];
            end
            default: begin
                disp_d = c2_q[W:0];
                abs_d  = abs2[W-1:0];
            end
        endcase
    end

    // Both stages move together under the shared pipeline advance
    always_ff @(posedge clk) begin
        if (rst) begin
            c0_q   <= '0;
            c1_q   <= '0;
            c2_q   <= '0;
            disp_q <= '0;
            abs_q  <= '0;
        end else if (en) begin
            c0_q   <= c0_d;
            c1_q   <= c1_d;
            c2_q   <= c2_d;
            disp_q <= disp_d;
            abs_q  <= abs_d;
        end
    end

    assign disp  = disp_q;
    assign abs_o = abs_q;

endmodule

// File: rtl/modd_vec_pipe.sv
// DIMS-axis minimum-image displacement pipe, one pair per cycle, stall-all
// valid/ready. Carries an opaque tag alongside each pair.
// Optional feature macro: MODD_R2_EN (adds stage 3: squared distance and
// cutoff compare, plus ports cutoff_sq / out_r2 / out_in_cutoff).
module modd_vec_pipe
    import modd_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DIMS  = DIMS_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIMS*W-1:0]     in_a,
    input  logic [DIMS*W-1:0]     in_b,
    input  logic [DIMS*W-1:0]     in_box,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIMS*(W+1)-1:0] out_disp,
    output logic [DIMS*W-1:0]     out_abs,
    output logic [TAG_W-1:0]      out_tag
`ifdef MODD_R2_EN
    ,
    input  logic [2*W+1:0]        cutoff_sq,
    output logic [2*W+1:0]        out_r2,
    output logic                  out_in_cutoff
`endif
);

    logic                       adv;
    logic                       in_fire;
    logic [LAT:1]               vld_pipe_d, vld_pipe_q;
    logic [LAT:1][TAG_W-1:0]    tag_pipe_d, tag_pipe_q;
    logic [DIMS-1:0][W:0]       ax_disp;
    logic [DIMS-1:0][W-1:0]     ax_abs;

    // A single advance moves every stage; it also gates new input
    assign adv       = !rst && (out_ready || !out_valid);
    assign in_ready  = adv;
    assign in_fire   = in_valid && adv;
    assign out_valid = vld_pipe_q[LAT];
    assign out_tag   = tag_pipe_q[LAT];

    // Valid/tag shift register; bubbles travel like pairs
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        tag_pipe_d = tag_pipe_q;
        if (adv) begin
            for (int s = LAT; s > 1; s--) begin
                vld_pipe_d[s] = vld_pipe_q[s-1];
                tag_pipe_d[s] = tag_pipe_q[s-1];
            end
            vld_pipe_d[1] = in_fire;
            tag_pipe_d[1] = in_tag;
        end
    end

    // Valid/tag registers; reset discards anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            tag_pipe_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            tag_pipe_q <= tag_pipe_d;
        end
    end

    for (genvar k = 0; k < DIMS; k++) begin : g_axis
        modd_axis #(
            .W (W)
        ) u_axis (
            .clk   (clk),
            .rst   (rst),
            .en    (adv),
            .a     (in_a[k*W +: W]),
            .b     (in_b[k*W +: W]),
            .m     (in_box[k*W +: W]),
            .disp  (ax_disp[k]),
            .abs_o (ax_abs[k])
        );
    end

`ifdef MODD_R2_EN
    localparam int R2_W = 2*W + 2;

    logic [R2_W-1:0]       r2_sum;
    logic [DIMS*(W+1)-1:0] s3_disp_d, s3_disp_q;
    logic [DIMS*W-1:0]     s3_abs_d, s3_abs_q;
    logic [R2_W-1:0]       r2_d, r2_q;
    logic                  in_cut_d, in_cut_q;

    // Stage 3 next-state: exact sum of squares; cutoff sampled on entry
    always_comb begin
        r2_sum = '0;
        for (int k = 0; k < DIMS; k++)
            r2_sum = r2_sum + R2_W'(ax_abs[k]) * R2_W'(ax_abs[k]);
        s3_disp_d = s3_disp_q;
        s3_abs_d  = s3_abs_q;
        r2_d      = r2_q;
        in_cut_d  = in_cut_q;
        if (adv) begin
            s3_disp_d = ax_disp;
            s3_abs_d  = ax_abs;
            r2_d      = r2_sum;
            in_cut_d  = (r2_sum <= cutoff_sq);
        end
    end

    // Stage 3 registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_disp_q <= '0;
            s3_abs_q  <= '0;
            r2_q      <= '0;
            in_cut_q  <= 1'b0;
        end else begin
            s3_disp_q <= s3_disp_d;
            s3_abs_q  <= s3_abs_d;
            r2_q      <= r2_d;
            in_cut_q  <= in_cut_d;
        end
    end

    assign out_disp      = s3_disp_q;
    assign out_abs       = s3_abs_q;
    assign out_r2        = r2_q;
    assign out_in_cutoff = in_cut_q;
`else
    assign out_disp = ax_disp;
    assign out_abs  = ax_abs;
`endif

endmodule

// File: tb/tb_modd_vec_pipe.sv
// Directed bench for modd_vec_pipe: hand-computed vectors, scoreboard of
// expected results pushed at accept and compared at output handshake.
// Optional feature macro: MODD_R2_EN (enables the r2/cutoff vectors).
module tb_modd_vec_pipe;
    import modd_pkg::*;

    localparam int W     = W_DEF;
    localparam int DIMS  = DIMS_DEF;
    localparam int TAG_W = TAG_W_DEF;
    localparam int DW    = DIMS*(W+1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid, in_ready, out_valid, out_ready;
    logic [DIMS*W-1:0]    in_a, in_b, in_box, out_abs;
    logic [DW-1:0]        out_disp;
    logic [TAG_W-1:0]     in_tag, out_tag;
`ifdef MODD_R2_EN
    logic [2*W+1:0]       cutoff_sq, out_r2;
    logic                 out_in_cutoff;
`endif

    always #5 clk = ~clk;

    modd_vec_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_box    (in_box),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_disp  (out_disp),
        .out_abs   (out_abs),
        .out_tag   (out_tag)
`ifdef MODD_R2_EN
        ,
        .cutoff_sq     (cutoff_sq),
        .out_r2        (out_r2),
        .out_in_cutoff (out_in_cutoff)
`endif
    );

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DW-1:0]     disp;
        logic [DIMS*W-1:0] abs;
    } exp_t;

    exp_t   exp_cur, mon_e;
    exp_t   q[$];
    int     out_cyc[$];
    int     n_chk = 0, n_err = 0, cyc = 0;
    int     k, base;
    logic   acc, held;
    logic [DW-1:0]     h_disp;
    logic [DIMS*W-1:0] h_abs;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ax(input int ax, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] m, input logic [W:0] d, input logic [W-1:0] ab);
        in_a   = axis_set(in_a, ax, a);
        in_b   = axis_set(in_b, ax, b);
        in_box = axis_set(in_box, ax, m);
        exp_cur.disp[ax*(W+1) +: W+1] = d;
        exp_cur.abs[ax*W +: W]        = ab;
    endtask

    // Hand-computed vectors: (a, b, M) -> (disp, abs) per axis
    task automatic load(input int v, input logic [TAG_W-1:0] tag);
        case (v)
            0: begin
                set_ax(0, 32'd10, 32'd90, 32'd100, 33'h1_FFFF_FFEC, 32'd20);
                set_ax(1, 32'd0,  32'd50, 32'd100, 33'h1_FFFF_FFCE, 32'd50);
                set_ax(2, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 33'h0_FFFF_FFFF, 32'hFFFF_FFFF);
            end
            1: begin
                set_ax(0, 32'd90, 32'd10, 32'd100, 33'd20, 32'd20);
                set_ax(1, 32'd5,  32'd5,  32'd7,   33'd0,  32'd0);
                set_ax(2, 32'd0,  32'hFFFF_FFCE, 32'd100, 33'h1_FFFF_FFCE, 32'd50);
            end
            2: begin
                set_ax(0, 32'd0,    32'd30, 32'hFFFF_FF9C, 33'd30, 32'd30);
                set_ax(1, 32'd1000, 32'd0,  32'hFFFF_FED4, 33'h1_FFFF_FD44, 32'd700);
                set_ax(2, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 33'h1_8000_0000, 32'h8000_0000);
            end
            default: begin
                set_ax(0, 32'd0, 32'd3, 32'd100, 33'd3, 32'd3);
                set_ax(1, 32'd0, 32'd4, 32'd100, 33'd4, 32'd4);
                set_ax(2, 32'd0, 32'd0, 32'd100, 33'd0, 32'd0);
            end
        endcase
        in_tag      = tag;
        exp_cur.tag = tag;
    endtask

    // Send one pair into an idle pipe and check accept->out_valid latency
    task automatic send_one(input int v, input logic [TAG_W-1:0] tag, input string lt);
        int cnt;
        load(v, tag);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        chk(lt, 128'(cnt), 128'(LAT));
    endtask

    // Scoreboard: push on input handshake, compare on output handshake
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
        end else begin
            if (in_valid && in_ready)
                q.push_back(exp_cur);
            if (out_valid && out_ready) begin
                out_cyc.push_back(cyc);
                if (q.size() == 0) begin
                    chk("spurious_out", 128'(out_tag), 128'(17'h1_0000));
                end else begin
                    mon_e = q.pop_front();
                    chk("out_tag",  128'(out_tag),  128'(mon_e.tag));
                    chk("out_disp", 128'(out_disp), 128'(mon_e.disp));
                    chk("out_abs",  128'(out_abs),  128'(mon_e.abs));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_box = '0; in_tag = '0; exp_cur = '0;
`ifdef MODD_R2_EN
        cutoff_sq = '0;
`endif
        repeat (3) tick();
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_disp",  128'(out_disp),  128'(0));
        chk("rst_out_abs",   128'(out_abs),   128'(0));
        chk("rst_out_tag",   128'(out_tag),   128'(0));
        chk("rst_in_ready",  128'(in_ready),  128'(0));

        // First accept the cycle after reset release
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", 128'(in_ready), 128'(1));
        send_one(0, 16'h0011, "lat_basic");
        tick();
        chk("drain_basic", 128'(out_valid), 128'(0));

        // Back-to-back stream at full rate
        base = out_cyc.size();
        for (int v = 0; v < 3; v++) begin
            load(v, TAG_W'(16'hA1 + v));
            in_valid = 1'b1;
            chk("tput_in_ready", 128'(in_ready), 128'(1));
            tick();
        end
        in_valid = 1'b0;
        repeat (LAT + 2) tick();
        chk("tput_count", 128'(out_cyc.size() - base), 128'(3));
        if (out_cyc.size() - base == 3)
            chk("tput_spacing", 128'(out_cyc[base+2] - out_cyc[base]), 128'(2));

        // Backpressure: out_ready low for 5 cycles while offering tags 1,2,3
        out_ready = 1'b0; k = 0; held = 1'b0;
        base = out_cyc.size();
        for (int c = 0; c < 5; c++) begin
            if (k < 3) begin
                load(k, TAG_W'(k + 1));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (c >= LAT)
                chk("bp_in_ready", 128'(in_ready), 128'(0));
            if (out_valid) begin
                if (!held) begin
                    held   = 1'b1;
                    h_disp = out_disp;
                    h_abs  = out_abs;
                    chk("bp_head_tag", 128'(out_tag), 128'(1));
                end else begin
                    chk("bp_hold_disp", 128'(out_disp), 128'(h_disp));
                    chk("bp_hold_abs",  128'(out_abs),  128'(h_abs));
                    chk("bp_hold_tag",  128'(out_tag),  128'(1));
                end
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) k++;
        end
        chk("bp_accepted", 128'(k), 128'(LAT));
        chk("bp_valid", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        #1;
        chk("bp_full_rdy", 128'(in_ready), 128'(1));
        for (int g = 0; g < 10 && k < 3; g++) begin
            load(k, TAG_W'(k + 1));
            in_valid = 1'b1;
            acc = in_ready;
            tick();
            if (acc) k++;
        end
        in_valid = 1'b0;
        repeat (LAT + 3) tick();
        chk("bp_all_in",  128'(k), 128'(3));
        chk("bp_out_cnt", 128'(out_cyc.size() - base), 128'(3));

        // Reset with two pairs in flight: they must vanish
        out_ready = 1'b0;
        load(0, 16'h0051); in_valid = 1'b1; tick();
        load(1, 16'h0052); tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_in_ready", 128'(in_ready), 128'(0));
        tick();
        chk("rst_mid_valid", 128'(out_valid), 128'(0));
        chk("rst_mid_tag",   128'(out_tag),   128'(0));
        rst = 1'b0; out_ready = 1'b1;
        for (int g = 0; g < 3; g++) begin
            chk("rst_no_ghost", 128'(out_valid), 128'(0));
            tick();
        end
        send_one(2, 16'h0053, "lat_after_rst");
        tick();

`ifdef MODD_R2_EN
        // Disp (3,4,0): r2 = 25 against cutoffs 25 and 24
        cutoff_sq = 25;
        send_one(3, 16'h0061, "lat_r2a");
        chk("r2_a",     128'(out_r2),        128'(25));
        chk("in_cut_a", 128'(out_in_cutoff), 128'(1));
        tick();
        cutoff_sq = 24;
        send_one(3, 16'h0062, "lat_r2b");
        chk("r2_b",     128'(out_r2),        128'(25));
        chk("in_cut_b", 128'(out_in_cutoff), 128'(0));
        tick();
`endif

        repeat (3) tick();
        chk("sb_empty", 128'(q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
